sram_access_ctrl: RTL and testbench

Controller for the MEM stage's external 16-bit SRAM. It sequences each 32-bit load or store as two half-word SRAM transfers with programmable wait states. It drives `ready` low to freeze the pipeline until the access completes. It sits between the MEM stage (`rd_en`/`wr_en`/`address`/`write_data`) and the SRAM pins; the hazard/freeze logic consumes `ready`.

---
 rtl/sram_access_ctrl_if.sv | 28 ++
 rtl/sram_access_ctrl.sv | 121 ++++++++++++
 tb/tb_sram_access_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// rtl/sram_access_ctrl_if.sv - MEM-stage request bus and external 16-bit SRAM pins
interface sram_access_ctrl_if #(
    parameter int ADDR_W = 18
) ();
    logic              rd_en;
    logic              wr_en;
    logic [31:0]       address;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              ready;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_out;
    logic              sram_dq_oe;
    logic [15:0]       sram_dq_in;
    logic              sram_we_n;
    logic              sram_oe_n;

    // master: pipeline side plus the SRAM device; slave: the controller
    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - 32-bit load/store as two wait-stated 16-bit SRAM transfers
module sram_access_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2,    // 1..15
    parameter int BASE_ADDR   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    sram_access_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        op_wr;
    logic [31:0] wdata_q;
    logic [31:0] offset;
    logic        req;
    logic        phase_last;
    logic        unused_bits;

    assign offset      = bus.address - 32'(BASE_ADDR);
    assign req         = bus.rd_en | bus.wr_en;
    assign phase_last  = (cnt == 4'(WAIT_CYCLES - 1));
    assign unused_bits = ^{offset[31:ADDR_W+1], offset[1:0]};

    // Low half is presented outside HI too; the bus is only driven when dq_oe is set.
    assign bus.sram_dq_out = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        bus.ready      = 1'b0;
        bus.sram_we_n  = 1'b1;
        bus.sram_oe_n  = 1'b1;
        bus.sram_dq_oe = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = ~req;
                if (req) begin
                    state_next = LO;
                end
            end
            LO, HI: begin
                if (phase_last) begin
                    state_next = (state == LO) ? HI : DONE;
                end
                if (op_wr) begin
                    bus.sram_dq_oe = 1'b1;
                    // last cycle of the phase is a data hold cycle unless the phase is one cycle long
                    bus.sram_we_n  = phase_last && (WAIT_CYCLES != 1);
                end else begin
                    bus.sram_oe_n  = 1'b0;
                end
            end
            DONE: begin
                bus.ready  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt           <= 4'd0;
            op_wr         <= 1'b0;
            wdata_q       <= 32'd0;
            bus.sram_addr <= '0;
            bus.read_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (req) begin
                        op_wr         <= bus.wr_en;
                        wdata_q       <= bus.write_data;
                        bus.sram_addr <= {offset[ADDR_W:2], 1'b0};
                    end
                end
                LO: begin
                    if (phase_last) begin
                        cnt           <= 4'd0;
                        bus.sram_addr <= {bus.sram_addr[ADDR_W-1:1], 1'b1};
                        if (!op_wr) begin
                            bus.read_data[15:0] <= bus.sram_dq_in;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HI: begin
                    if (phase_last) begin
                        cnt <= 4'd0;
                        if (!op_wr) begin
                            bus.read_data[31:16] <= bus.sram_dq_in;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: cnt <= 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - directed vector bench for sram_access_ctrl with an SRAM model
module tb_sram_access_ctrl;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        drop;       // release the request during LO
        logic [17:0] exp_lo;     // expected low half-word SRAM address
        logic [31:0] exp_rdata;  // expected read_data in DONE
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] mem [0:63];
    int          n_cmp;
    int          n_fail;
    vec_t        vecs [8];

    sram_access_ctrl_if #(.ADDR_W(18)) bus ();

    sram_access_ctrl #(
        .ADDR_W      (18),
        .WAIT_CYCLES (2),
        .BASE_ADDR   (1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!bus.sram_we_n) mem[bus.sram_addr[5:0]] <= bus.sram_dq_out;
    end
    assign bus.sram_dq_in = bus.sram_oe_n ? 16'h0000 : mem[bus.sram_addr[5:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_access(input vec_t v, input int idx);
        logic wr_op;
        logic rd_op;
        wr_op = v.wr;
        rd_op = v.rd & ~v.wr;
        bus.rd_en      = v.rd;
        bus.wr_en      = v.wr;
        bus.address    = v.addr;
        bus.write_data = v.wdata;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d c%0d ready", idx, c), 32'(bus.ready), 32'(c == 5));
            if (c >= 1 && c <= 4) begin
                chk($sformatf("v%0d c%0d sram_addr", idx, c), 32'(bus.sram_addr),
                    32'(v.exp_lo) + 32'(c >= 3));
                chk($sformatf("v%0d c%0d we_n", idx, c), 32'(bus.sram_we_n),
                    32'(!(wr_op && (c == 1 || c == 3))));
                chk($sformatf("v%0d c%0d oe_n", idx, c), 32'(bus.sram_oe_n), 32'(!rd_op));
                chk($sformatf("v%0d c%0d dq_oe", idx, c), 32'(bus.sram_dq_oe), 32'(wr_op));
                if (wr_op)
                    chk($sformatf("v%0d c%0d dq_out", idx, c), 32'(bus.sram_dq_out),
                        (c <= 2) ? 32'(v.wdata[15:0]) : 32'(v.wdata[31:16]));
            end
            if (c == 5) begin
                chk($sformatf("v%0d done read_data", idx), bus.read_data, v.exp_rdata);
                chk($sformatf("v%0d done we_n", idx), 32'(bus.sram_we_n), 32'd1);
                chk($sformatf("v%0d done oe_n", idx), 32'(bus.sram_oe_n), 32'd1);
            end
            @(posedge clk);
            #1;
            if ((c == 0 && v.drop) || c == 5) begin
                bus.rd_en   = 1'b0;
                bus.wr_en   = 1'b0;
                bus.address = 32'hFFFF_0000;
            end
        end
        if (wr_op) begin
            chk($sformatf("v%0d mem lo", idx), 32'(mem[v.exp_lo[5:0]]), 32'(v.wdata[15:0]));
            chk($sformatf("v%0d mem hi", idx), 32'(mem[v.exp_lo[5:0] + 6'd1]), 32'(v.wdata[31:16]));
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

        vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0, 18'h00004, 32'h00000000};
        vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 1'b0, 18'h00004, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'd1040, 32'h12345678, 1'b0, 18'h00008, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b0, 18'h00000, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 1'b0, 18'h00000, 32'hCAFEF00D};
        vecs[5] = '{1'b0, 1'b1, 32'd1022, 32'h0BADF00D, 1'b0, 18'h3FFFE, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 32'd1022, 32'h00000000, 1'b1, 18'h3FFFE, 32'h0BADF00D};
        vecs[7] = '{1'b1, 1'b0, 32'd1035, 32'h00000000, 1'b0, 18'h00004, 32'hDEADBEEF};

        rst            = 1'b0;
        bus.rd_en      = 1'b1;
        bus.wr_en      = 1'b0;
        bus.address    = 32'd1032;
        bus.write_data = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst ready", 32'(bus.ready), 32'd0);
        chk("rst read_data", bus.read_data, 32'd0);
        chk("rst we_n", 32'(bus.sram_we_n), 32'd1);
        chk("rst oe_n", 32'(bus.sram_oe_n), 32'd1);
        chk("rst dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        chk("rst sram_addr", 32'(bus.sram_addr), 32'd0);
        chk("rst dq_out", 32'(bus.sram_dq_out), 32'd0);
        bus.rd_en = 1'b0;
        #1;
        chk("rst idle ready", 32'(bus.ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post rst ready", 32'(bus.ready), 32'd1);
        chk("post rst oe_n", 32'(bus.sram_oe_n), 32'd1);
        @(posedge clk);
        #1;

        // back-to-back: each access starts in the cycle right after the previous DONE
        for (int i = 0; i < 8; i++) do_access(vecs[i], i);

        // reset during the HI phase of a write
        bus.wr_en      = 1'b1;
        bus.address    = 32'd1040;
        bus.write_data = 32'hAAAA5555;
        repeat (3) @(posedge clk);
        #1;
        chk("mid we_n before", 32'(bus.sram_we_n), 32'd0);
        chk("mid sram_addr before", 32'(bus.sram_addr), 32'd9);
        rst = 1'b0;
        #1;
        chk("mid we_n after", 32'(bus.sram_we_n), 32'd1);
        chk("mid dq_oe after", 32'(bus.sram_dq_oe), 32'd0);
        chk("mid sram_addr after", 32'(bus.sram_addr), 32'd0);
        bus.wr_en = 1'b0;
        #1;
        chk("mid ready idle", 32'(bus.ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid mem8 written", 32'(mem[8]), 32'h5555);
        chk("mid mem9 kept", 32'(mem[9]), 32'h1234);
        chk("mid we_n idle", 32'(bus.sram_we_n), 32'd1);
        chk("mid ready final", 32'(bus.ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
